// File: rtl/axi4_lite_reg_slice.sv
// -----------------------------------------------------------------------------
// axi4_lite_reg_slice
//
// Full-throughput AXI4-Lite register slice. It sits between an AXI4-Lite
// master (s-side, "driver") and an AXI4-Lite slave (m-side, "memory slave")
// and timing-breaks all five channels. Every valid, ready and payload output
// is driven directly from a flop.
//
// Each channel goes through its own 2-entry skid stage (axi4_lite_skid_stage,
// defined below in this file). Each stage adds one cycle of latency,
// sustains one beat per cycle and preserves beat order. The five channels are
// independent: AW and W are never coupled.
//
// Parameters
//   AWIDTH  address width of AW/AR payload
//   DWIDTH  data width of W/R payload; strobe width is DWIDTH/8
//
// Ports (s = faces driver, m = faces slave; ready runs opposite to valid)
//   i_aClk, i_aResetn                          clock, async active-low reset
//   i_sAw*/o_sAwReady -> o_mAw*/i_mAwReady     write address, driver -> slave
//   i_sW* /o_sWReady  -> o_mW* /i_mWReady      write data,    driver -> slave
//   i_mB* /o_mBReady  -> o_sB* /i_sBReady      write resp,    slave  -> driver
//   i_sAr*/o_sArReady -> o_mAr*/i_mArReady     read address,  driver -> slave
//   i_mR* /o_mRReady  -> o_sR* /i_sRReady      read data,     slave  -> driver
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// axi4_lite_skid_stage
//
// One valid/ready channel stage built from an output register and a skid
// register. in_ready, out_valid and out_data are all flops.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   in_valid, in_ready, in_data      upstream side
//   out_valid, out_ready, out_data   downstream side
// -----------------------------------------------------------------------------
module axi4_lite_skid_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             sk_valid;
  logic [WIDTH-1:0] sk_data;

  logic             out_valid_nxt;
  logic [WIDTH-1:0] out_data_nxt;
  logic             sk_valid_nxt;
  logic [WIDTH-1:0] sk_data_nxt;

  logic in_hs;
  logic out_load;

  assign in_hs = in_valid & in_ready;

  // The output register may take a new beat when it is empty or when its
  // current beat leaves this cycle (!out_valid | (out_valid & out_ready)).
  assign out_load = !out_valid | out_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    sk_valid_nxt  = sk_valid;
    sk_data_nxt   = sk_data;

    if (out_load) begin
      if (sk_valid) begin
        // Oldest beat lives in the skid; it goes first to keep ordering.
        out_valid_nxt = 1'b1;
        out_data_nxt  = sk_data;
        sk_valid_nxt  = 1'b0;
      end else if (in_hs) begin
        // Accept and drain in the same cycle: bypass the skid entirely.
        out_valid_nxt = 1'b1;
        out_data_nxt  = in_data;
      end else begin
        out_valid_nxt = 1'b0;
      end
    end else if (in_hs) begin
      // Output is stalled: park the beat that was already in flight because
      // in_ready is registered and could not react in the same cycle.
      sk_valid_nxt = 1'b1;
      sk_data_nxt  = in_data;
    end
  end

  // NOTE: state flops use non-blocking assignments only, so every flop
  // samples the pre-edge values and ordering between always blocks is moot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sk_valid  <= 1'b0;
      sk_data   <= '0;
      in_ready  <= 1'b0;
    end else begin
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      sk_valid  <= sk_valid_nxt;
      sk_data   <= sk_data_nxt;
      // Stop accepting as soon as the skid holds a beat; nothing new can be
      // taken until it has moved to the output register.
      in_ready  <= !sk_valid_nxt;
    end
  end

endmodule

module axi4_lite_reg_slice #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32
) (
  input  logic                i_aClk,
  input  logic                i_aResetn,

  // AW from driver / to slave
  input  logic                i_sAwValid,
  output logic                o_sAwReady,
  input  logic [AWIDTH-1:0]   i_sAwAddr,
  input  logic [2:0]          i_sAwProt,
  output logic                o_mAwValid,
  input  logic                i_mAwReady,
  output logic [AWIDTH-1:0]   o_mAwAddr,
  output logic [2:0]          o_mAwProt,

  // W from driver / to slave
  input  logic                i_sWValid,
  output logic                o_sWReady,
  input  logic [DWIDTH-1:0]   i_sWData,
  input  logic [DWIDTH/8-1:0] i_sWStrb,
  output logic                o_mWValid,
  input  logic                i_mWReady,
  output logic [DWIDTH-1:0]   o_mWData,
  output logic [DWIDTH/8-1:0] o_mWStrb,

  // B from slave / to driver
  input  logic                i_mBValid,
  output logic                o_mBReady,
  input  logic [1:0]          i_mBResp,
  output logic                o_sBValid,
  input  logic                i_sBReady,
  output logic [1:0]          o_sBResp,

  // AR from driver / to slave
  input  logic                i_sArValid,
  output logic                o_sArReady,
  input  logic [AWIDTH-1:0]   i_sArAddr,
  input  logic [2:0]          i_sArProt,
  output logic                o_mArValid,
  input  logic                i_mArReady,
  output logic [AWIDTH-1:0]   o_mArAddr,
  output logic [2:0]          o_mArProt,

  // R from slave / to driver
  input  logic                i_mRValid,
  output logic                o_mRReady,
  input  logic [DWIDTH-1:0]   i_mRData,
  input  logic [1:0]          i_mRResp,
  output logic                o_sRValid,
  input  logic                i_sRReady,
  output logic [DWIDTH-1:0]   o_sRData,
  output logic [1:0]          o_sRResp
);

  localparam int SWIDTH   = DWIDTH / 8;
  localparam int AX_WIDTH = AWIDTH + 3;
  localparam int W_WIDTH  = DWIDTH + SWIDTH;
  localparam int B_WIDTH  = 2;
  localparam int R_WIDTH  = DWIDTH + 2;

  // ---------------------------------------------------------------------------
  // Write address channel
  // ---------------------------------------------------------------------------
  axi4_lite_skid_stage #(.WIDTH(AX_WIDTH)) u_aw (
    .clk       (i_aClk),
    .rst_n     (i_aResetn),
    .in_valid  (i_sAwValid),
    .in_ready  (o_sAwReady),
    .in_data   ({i_sAwProt, i_sAwAddr}),
    .out_valid (o_mAwValid),
    .out_ready (i_mAwReady),
    .out_data  ({o_mAwProt, o_mAwAddr})
  );

  // ---------------------------------------------------------------------------
  // Write data channel
  // ---------------------------------------------------------------------------
  axi4_lite_skid_stage #(.WIDTH(W_WIDTH)) u_w (
    .clk       (i_aClk),
    .rst_n     (i_aResetn),
    .in_valid  (i_sWValid),
    .in_ready  (o_sWReady),
    .in_data   ({i_sWStrb, i_sWData}),
    .out_valid (o_mWValid),
    .out_ready (i_mWReady),
    .out_data  ({o_mWStrb, o_mWData})
  );

  // ---------------------------------------------------------------------------
  // Write response channel (slave -> driver); response codes pass unchanged
  // ---------------------------------------------------------------------------
  axi4_lite_skid_stage #(.WIDTH(B_WIDTH)) u_b (
    .clk       (i_aClk),
    .rst_n     (i_aResetn),
    .in_valid  (i_mBValid),
    .in_ready  (o_mBReady),
    .in_data   (i_mBResp),
    .out_valid (o_sBValid),
    .out_ready (i_sBReady),
    .out_data  (o_sBResp)
  );

  // ---------------------------------------------------------------------------
  // Read address channel
  // ---------------------------------------------------------------------------
  axi4_lite_skid_stage #(.WIDTH(AX_WIDTH)) u_ar (
    .clk       (i_aClk),
    .rst_n     (i_aResetn),
    .in_valid  (i_sArValid),
    .in_ready  (o_sArReady),
    .in_data   ({i_sArProt, i_sArAddr}),
    .out_valid (o_mArValid),
    .out_ready (i_mArReady),
    .out_data  ({o_mArProt, o_mArAddr})
  );

  // ---------------------------------------------------------------------------
  // Read data channel (slave -> driver)
  // ---------------------------------------------------------------------------
  axi4_lite_skid_stage #(.WIDTH(R_WIDTH)) u_r (
    .clk       (i_aClk),
    .rst_n     (i_aResetn),
    .in_valid  (i_mRValid),
    .in_ready  (o_mRReady),
    .in_data   ({i_mRResp, i_mRData}),
    .out_valid (o_sRValid),
    .out_ready (i_sRReady),
    .out_data  ({o_sRResp, o_sRData})
  );

endmodule
